// File: rtl/riscv_pkg.sv
// Shared definitions for the memory-access stage.
//   MEM_SIZE_*     encodings of the 2-bit access size field
//   mem_state_e    IDLE/WAIT states of the memory request FSM
//   is_misaligned  flags accesses whose address does not fit the requested size
package riscv_pkg;

    localparam logic [1:0] MEM_SIZE_B   = 2'b00;
    localparam logic [1:0] MEM_SIZE_H   = 2'b01;
    localparam logic [1:0] MEM_SIZE_W   = 2'b10;
    localparam logic [1:0] MEM_SIZE_ILL = 2'b11;

    typedef enum logic {
        MEM_IDLE,
        MEM_WAIT
    } mem_state_e;

    // The illegal size encoding is reported the same way as a misaligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            MEM_SIZE_B: bad = 1'b0;
            MEM_SIZE_H: bad = addr_lo[0];
            MEM_SIZE_W: bad = |addr_lo;
            default:    bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus.
//   req    request pending (held until the ack cycle)
//   we     1 = write
//   addr   word-aligned byte address
//   wdata  lane-replicated store data
//   be     byte enables
//   ack    request complete; rdata valid in this cycle for reads
//   rdata  read word
// master: the memory stage; slave: the data memory.
interface mem_access_stage_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32
) ();

    logic                     req;
    logic                     we;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
    logic [3:0]               be;
    logic                     ack;
    logic [DATA_WIDTH-1:0]    rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );

endinterface

// File: rtl/load_data_align.sv
// Combinational load alignment: picks the addressed byte/half out of the read
// word and sign- or zero-extends it. Word loads pass through unchanged.
//   rdata        read word from memory
//   addr_lo      byte offset within the word
//   size         access size (B/H/W)
//   is_unsigned  zero-extend instead of sign-extend
//   data         extended result
module load_data_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic        byte_ext;
    logic        half_ext;

    always_comb begin
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        byte_ext = ~is_unsigned & byte_sel[7];
        half_ext = ~is_unsigned & half_sel[15];

        case (size)
            MEM_SIZE_B: data = {{24{byte_ext}}, byte_sel};
            MEM_SIZE_H: data = {{16{half_ext}}, half_sel};
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage downstream of execute. Non-memory ops pass to writeback with one
// cycle of latency; aligned loads/stores are issued on the dmem bus and the stage
// stalls upstream until the ack. Misaligned/illegal-size accesses raise
// exception bit [3] (load) or [4] (store) without touching memory.
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_*                 execute results for the instruction in flight
//   o_stall             upstream must hold its inputs this cycle
//   dmem                data-memory bus (master side)
//   o_valid ... o_ecall registered writeback entry
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned REG_NUM       = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_exe_mux_out1,
    input  logic [DATA_WIDTH-1:0]      i_exe_mux_out2,
    input  logic                       i_rf_wr_en,
    input  logic [$clog2(REG_NUM)-1:0] i_rd_addr,
    input  logic                       i_is_load,
    input  logic                       i_is_store,
    input  logic [1:0]                 i_mem_size,
    input  logic                       i_mem_load_unsigned,
    input  logic [ADDRESS_WIDTH-1:0]   i_pc,
    input  logic [2:0]                 i_exception,
    input  logic                       i_ecall,
    output logic                       o_stall,
    mem_access_stage_if.master         dmem,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_wb_data,
    output logic                       o_rf_wr_en,
    output logic [$clog2(REG_NUM)-1:0] o_rd_addr,
    output logic [ADDRESS_WIDTH-1:0]   o_pc,
    output logic [4:0]                 o_exception,
    output logic                       o_ecall
);

    localparam int unsigned RW = $clog2(REG_NUM);

    mem_state_e state_q, state_d;

    // Request registers, held stable for the whole WAIT period.
    logic [ADDRESS_WIDTH-1:0] req_addr_q, req_addr_d;
    logic                     req_we_q, req_we_d;
    logic [3:0]               req_be_q, req_be_d;
    logic [DATA_WIDTH-1:0]    req_wdata_q, req_wdata_d;
    logic [1:0]               req_size_q, req_size_d;
    logic                     req_unsigned_q, req_unsigned_d;
    logic                     req_rf_wr_en_q, req_rf_wr_en_d;
    logic [RW-1:0]            req_rd_q, req_rd_d;
    logic [ADDRESS_WIDTH-1:0] req_pc_q, req_pc_d;
    logic                     req_exc2_q, req_exc2_d;
    logic                     req_ecall_q, req_ecall_d;

    // Writeback output registers.
    logic                     valid_q, valid_d;
    logic [DATA_WIDTH-1:0]    wb_data_q, wb_data_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic [RW-1:0]            rd_q, rd_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [4:0]               exception_q, exception_d;
    logic                     ecall_q, ecall_d;

    logic                     mem_op;
    logic                     fd_exc;
    logic                     misaligned;
    logic [DATA_WIDTH-1:0]    st_wdata;
    logic [3:0]               st_be;
    logic [DATA_WIDTH-1:0]    load_data;

    assign mem_op     = i_is_load | i_is_store;
    assign fd_exc     = |i_exception[1:0];
    assign misaligned = is_misaligned(i_mem_size, i_exe_mux_out1[1:0]);

    // Store lane replication; the memory picks lanes via be.
    always_comb begin
        case (i_mem_size)
            MEM_SIZE_B: begin
                st_wdata = {4{i_exe_mux_out2[7:0]}};
                st_be    = 4'b0001 << i_exe_mux_out1[1:0];
            end
            MEM_SIZE_H: begin
                st_wdata = {2{i_exe_mux_out2[15:0]}};
                st_be    = 4'b0011 << i_exe_mux_out1[1:0];
            end
            default: begin
                st_wdata = i_exe_mux_out2;
                st_be    = 4'hF;
            end
        endcase
    end

    load_data_align u_load_data_align (
        .rdata       (dmem.rdata),
        .addr_lo     (req_addr_q[1:0]),
        .size        (req_size_q),
        .is_unsigned (req_unsigned_q),
        .data        (load_data)
    );

    always_comb begin
        state_d        = state_q;
        req_addr_d     = req_addr_q;
        req_we_d       = req_we_q;
        req_be_d       = req_be_q;
        req_wdata_d    = req_wdata_q;
        req_size_d     = req_size_q;
        req_unsigned_d = req_unsigned_q;
        req_rf_wr_en_d = req_rf_wr_en_q;
        req_rd_d       = req_rd_q;
        req_pc_d       = req_pc_q;
        req_exc2_d     = req_exc2_q;
        req_ecall_d    = req_ecall_q;
        valid_d        = 1'b0;
        rf_wr_en_d     = 1'b0;
        wb_data_d      = wb_data_q;
        rd_d           = rd_q;
        pc_d           = pc_q;
        exception_d    = exception_q;
        ecall_d        = ecall_q;

        case (state_q)
            MEM_IDLE: begin
                if (i_valid) begin
                    if (mem_op && !fd_exc && !misaligned) begin
                        state_d        = MEM_WAIT;
                        req_addr_d     = i_exe_mux_out1;
                        req_we_d       = i_is_store & ~i_is_load;
                        req_be_d       = i_is_load ? 4'hF : st_be;
                        req_wdata_d    = st_wdata;
                        req_size_d     = i_mem_size;
                        req_unsigned_d = i_mem_load_unsigned;
                        req_rf_wr_en_d = i_rf_wr_en;
                        req_rd_d       = i_rd_addr;
                        req_pc_d       = i_pc;
                        req_exc2_d     = i_exception[2];
                        req_ecall_d    = i_ecall;
                    end else begin
                        // Single-cycle result: ALU op, faulted op or misaligned access.
                        valid_d     = 1'b1;
                        wb_data_d   = i_exe_mux_out1;
                        rd_d        = i_rd_addr;
                        pc_d        = i_pc;
                        ecall_d     = i_ecall;
                        exception_d = {2'b00, i_exception};
                        if (fd_exc) begin
                            rf_wr_en_d = 1'b0;
                        end else if (mem_op) begin
                            exception_d[3] = i_is_load;
                            exception_d[4] = i_is_store & ~i_is_load;
                        end else begin
                            rf_wr_en_d = i_rf_wr_en;
                        end
                    end
                end
            end
            MEM_WAIT: begin
                if (dmem.ack) begin
                    state_d     = MEM_IDLE;
                    valid_d     = 1'b1;
                    wb_data_d   = req_we_q ? '0 : load_data;
                    rf_wr_en_d  = req_rf_wr_en_q & ~req_we_q;
                    rd_d        = req_rd_q;
                    pc_d        = req_pc_q;
                    exception_d = {2'b00, req_exc2_q, 2'b00};
                    ecall_d     = req_ecall_q;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= MEM_IDLE;
            req_addr_q     <= '0;
            req_we_q       <= 1'b0;
            req_be_q       <= '0;
            req_wdata_q    <= '0;
            req_size_q     <= '0;
            req_unsigned_q <= 1'b0;
            req_rf_wr_en_q <= 1'b0;
            req_rd_q       <= '0;
            req_pc_q       <= '0;
            req_exc2_q     <= 1'b0;
            req_ecall_q    <= 1'b0;
            valid_q        <= 1'b0;
            wb_data_q      <= '0;
            rf_wr_en_q     <= 1'b0;
            rd_q           <= '0;
            pc_q           <= '0;
            exception_q    <= '0;
            ecall_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_addr_q     <= req_addr_d;
            req_we_q       <= req_we_d;
            req_be_q       <= req_be_d;
            req_wdata_q    <= req_wdata_d;
            req_size_q     <= req_size_d;
            req_unsigned_q <= req_unsigned_d;
            req_rf_wr_en_q <= req_rf_wr_en_d;
            req_rd_q       <= req_rd_d;
            req_pc_q       <= req_pc_d;
            req_exc2_q     <= req_exc2_d;
            req_ecall_q    <= req_ecall_d;
            valid_q        <= valid_d;
            wb_data_q      <= wb_data_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rd_q           <= rd_d;
            pc_q           <= pc_d;
            exception_q    <= exception_d;
            ecall_q        <= ecall_d;
        end
    end

    assign o_stall     = (state_q == MEM_WAIT);
    assign dmem.req    = (state_q == MEM_WAIT);
    assign dmem.we     = req_we_q;
    assign dmem.addr   = {req_addr_q[ADDRESS_WIDTH-1:2], 2'b00};
    assign dmem.wdata  = req_wdata_q;
    assign dmem.be     = req_be_q;

    assign o_valid     = valid_q;
    assign o_wb_data   = wb_data_q;
    assign o_rf_wr_en  = rf_wr_en_q;
    assign o_rd_addr   = rd_q;
    assign o_pc        = pc_q;
    assign o_exception = exception_q;
    assign o_ecall     = ecall_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [31:0] i_exe_mux_out1;
    logic [31:0] i_exe_mux_out2;
    logic        i_rf_wr_en;
    logic [4:0]  i_rd_addr;
    logic        i_is_load;
    logic        i_is_store;
    logic [1:0]  i_mem_size;
    logic        i_mem_load_unsigned;
    logic [31:0] i_pc;
    logic [2:0]  i_exception;
    logic        i_ecall;
    logic        o_stall;
    logic        o_valid;
    logic [31:0] o_wb_data;
    logic        o_rf_wr_en;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_pc;
    logic [4:0]  o_exception;
    logic        o_ecall;

    int n_checks = 0;
    int n_fail   = 0;

    mem_access_stage_if #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32)) dmem_if ();

    mem_access_stage #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .REG_NUM(32)) dut (
        .i_clk               (clk),
        .i_rst               (rst),
        .i_valid             (i_valid),
        .i_exe_mux_out1      (i_exe_mux_out1),
        .i_exe_mux_out2      (i_exe_mux_out2),
        .i_rf_wr_en          (i_rf_wr_en),
        .i_rd_addr           (i_rd_addr),
        .i_is_load           (i_is_load),
        .i_is_store          (i_is_store),
        .i_mem_size          (i_mem_size),
        .i_mem_load_unsigned (i_mem_load_unsigned),
        .i_pc                (i_pc),
        .i_exception         (i_exception),
        .i_ecall             (i_ecall),
        .o_stall             (o_stall),
        .dmem                (dmem_if),
        .o_valid             (o_valid),
        .o_wb_data           (o_wb_data),
        .o_rf_wr_en          (o_rf_wr_en),
        .o_rd_addr           (o_rd_addr),
        .o_pc                (o_pc),
        .o_exception         (o_exception),
        .o_ecall             (o_ecall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pc_of(input logic [4:0] rd);
        return 32'h0000_0800 | {25'd0, rd, 2'b00};
    endfunction

    task automatic set_op(input logic ld, input logic st, input logic [1:0] size, input logic uns,
                          input logic [31:0] a, input logic [31:0] d, input logic wr,
                          input logic [4:0] rd, input logic [2:0] exc);
        i_valid             = 1'b1;
        i_is_load           = ld;
        i_is_store          = st;
        i_mem_size          = size;
        i_mem_load_unsigned = uns;
        i_exe_mux_out1      = a;
        i_exe_mux_out2      = d;
        i_rf_wr_en          = wr;
        i_rd_addr           = rd;
        i_pc                = pc_of(rd);
        i_exception         = exc;
        i_ecall             = 1'b0;
    endtask

    task automatic idle_in();
        i_valid             = 1'b0;
        i_is_load           = 1'b0;
        i_is_store          = 1'b0;
        i_mem_size          = 2'b10;
        i_mem_load_unsigned = 1'b0;
        i_exe_mux_out1      = 32'h0;
        i_exe_mux_out2      = 32'h0;
        i_rf_wr_en          = 1'b0;
        i_rd_addr           = 5'd0;
        i_pc                = 32'h0;
        i_exception         = 3'b000;
        i_ecall             = 1'b0;
    endtask

    // Load with ack in the first WAIT cycle.
    task automatic do_load(input string tag, input logic [1:0] size, input logic uns,
                           input logic [31:0] a, input logic [31:0] rdata, input logic [31:0] exp);
        set_op(1'b1, 1'b0, size, uns, a, 32'h0, 1'b1, 5'd7, 3'b000);
        @(negedge clk);
        idle_in();
        check({tag, "_req"}, dmem_if.req, 1'b1);
        check({tag, "_stall"}, o_stall, 1'b1);
        check({tag, "_addr"}, dmem_if.addr, {a[31:2], 2'b00});
        check({tag, "_we"}, dmem_if.we, 1'b0);
        check({tag, "_valid_wait"}, o_valid, 1'b0);
        dmem_if.ack   = 1'b1;
        dmem_if.rdata = rdata;
        @(negedge clk);
        dmem_if.ack = 1'b0;
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_data"}, o_wb_data, exp);
        check({tag, "_wr"}, o_rf_wr_en, 1'b1);
        check({tag, "_rd"}, o_rd_addr, 5'd7);
        check({tag, "_pc"}, o_pc, pc_of(5'd7));
        check({tag, "_req_done"}, dmem_if.req, 1'b0);
        check({tag, "_stall_done"}, o_stall, 1'b0);
    endtask

    task automatic do_store(input string tag, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] be, input logic [31:0] wd);
        set_op(1'b0, 1'b1, size, 1'b0, a, d, 1'b1, 5'd9, 3'b000);
        @(negedge clk);
        idle_in();
        check({tag, "_req"}, dmem_if.req, 1'b1);
        check({tag, "_we"}, dmem_if.we, 1'b1);
        check({tag, "_addr"}, dmem_if.addr, {a[31:2], 2'b00});
        check({tag, "_be"}, dmem_if.be, be);
        check({tag, "_wdata"}, dmem_if.wdata, wd);
        dmem_if.ack = 1'b1;
        @(negedge clk);
        dmem_if.ack = 1'b0;
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_wr"}, o_rf_wr_en, 1'b0);
        check({tag, "_req_done"}, dmem_if.req, 1'b0);
    endtask

    task automatic do_bad(input string tag, input logic ld, input logic st, input logic [1:0] size,
                          input logic [31:0] a, input logic [2:0] exc, input logic [4:0] exp_exc);
        set_op(ld, st, size, 1'b0, a, 32'hCAFE_F00D, 1'b1, 5'd3, exc);
        @(negedge clk);
        idle_in();
        check({tag, "_req"}, dmem_if.req, 1'b0);
        check({tag, "_stall"}, o_stall, 1'b0);
        check({tag, "_valid"}, o_valid, 1'b1);
        check({tag, "_wr"}, o_rf_wr_en, 1'b0);
        check({tag, "_exc"}, o_exception, exp_exc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vcount;
        idle_in();
        rst           = 1'b1;
        dmem_if.ack   = 1'b0;
        dmem_if.rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_valid", o_valid, 1'b0);
        check("rst_req", dmem_if.req, 1'b0);
        check("rst_stall", o_stall, 1'b0);
        check("rst_wr", o_rf_wr_en, 1'b0);
        check("rst_data", o_wb_data, 32'h0);
        check("rst_exc", o_exception, 5'h0);
        check("rst_ecall", o_ecall, 1'b0);
        rst = 1'b0;

        // ALU op, one-cycle latency
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 1'b1, 5'd5, 3'b000);
        i_ecall = 1'b1;
        @(negedge clk);
        idle_in();
        check("alu_valid", o_valid, 1'b1);
        check("alu_data", o_wb_data, 32'h0000_1234);
        check("alu_rd", o_rd_addr, 5'd5);
        check("alu_wr", o_rf_wr_en, 1'b1);
        check("alu_pc", o_pc, pc_of(5'd5));
        check("alu_ecall", o_ecall, 1'b1);
        check("alu_stall", o_stall, 1'b0);
        check("alu_req", dmem_if.req, 1'b0);
        @(negedge clk);
        check("bubble_valid", o_valid, 1'b0);
        check("bubble_wr", o_rf_wr_en, 1'b0);

        // Loads
        do_load("lb", 2'b00, 1'b0, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80);
        do_load("lbu", 2'b00, 1'b1, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080);
        do_load("lb1", 2'b00, 1'b0, 32'h0000_1001, 32'h0000_7F00, 32'h0000_007F);
        do_load("lh", 2'b01, 1'b0, 32'h0000_1002, 32'h8001_1234, 32'hFFFF_8001);
        do_load("lhu", 2'b01, 1'b1, 32'h0000_1000, 32'h0000_F00F, 32'h0000_F00F);
        do_load("lw", 2'b10, 1'b1, 32'h0000_1004, 32'h89AB_CDEF, 32'h89AB_CDEF);

        // Stores
        do_store("sh", 2'b01, 32'h0000_2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sb", 2'b00, 32'h0000_2001, 32'h0000_0055, 4'b0010, 32'h5555_5555);
        do_store("sw", 2'b10, 32'h0000_2008, 32'hDEAD_0001, 4'b1111, 32'hDEAD_0001);

        // Misaligned / illegal size / upstream faults
        do_bad("lw_mis", 1'b1, 1'b0, 2'b10, 32'h0000_1001, 3'b000, 5'b01000);
        do_bad("sw_mis", 1'b0, 1'b1, 2'b10, 32'h0000_1002, 3'b000, 5'b10000);
        do_bad("lh_mis", 1'b1, 1'b0, 2'b01, 32'h0000_1003, 3'b000, 5'b01000);
        do_bad("size_ill", 1'b1, 1'b0, 2'b11, 32'h0000_1000, 3'b000, 5'b01000);
        do_bad("fd_exc", 1'b1, 1'b0, 2'b10, 32'h0000_1000, 3'b010, 5'b00010);

        // Execute overflow flag passes through without suppressing the write
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_ABCD, 32'h0, 1'b1, 5'd4, 3'b100);
        @(negedge clk);
        idle_in();
        check("ovf_valid", o_valid, 1'b1);
        check("ovf_wr", o_rf_wr_en, 1'b1);
        check("ovf_exc", o_exception, 5'b00100);
        check("ovf_data", o_wb_data, 32'h0000_ABCD);

        // LW with ack after three idle WAIT cycles
        vcount = 0;
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3000, 32'h0, 1'b1, 5'd12, 3'b000);
        @(negedge clk);
        idle_in();
        for (int i = 0; i < 4; i++) begin
            check("slow_req", dmem_if.req, 1'b1);
            check("slow_addr", dmem_if.addr, 32'h0000_3000);
            check("slow_stall", o_stall, 1'b1);
            if (o_valid) vcount++;
            if (i == 3) begin
                dmem_if.ack   = 1'b1;
                dmem_if.rdata = 32'hDEAD_BEEF;
            end
            @(negedge clk);
        end
        dmem_if.ack = 1'b0;
        if (o_valid) vcount++;
        check("slow_data", o_wb_data, 32'hDEAD_BEEF);
        check("slow_rd", o_rd_addr, 5'd12);
        check("slow_stall_done", o_stall, 1'b0);
        @(negedge clk);
        if (o_valid) vcount++;
        check("slow_valid_count", vcount, 1);

        // Reset while waiting on memory
        set_op(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_4000, 32'h0, 1'b1, 5'd8, 3'b000);
        @(negedge clk);
        idle_in();
        check("rw_req", dmem_if.req, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rw_req_after", dmem_if.req, 1'b0);
        check("rw_valid_after", o_valid, 1'b0);
        check("rw_stall_after", o_stall, 1'b0);
        dmem_if.ack   = 1'b1;
        dmem_if.rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_if.ack = 1'b0;
        check("late_ack_valid", o_valid, 1'b0);
        check("late_ack_req", dmem_if.req, 1'b0);
        set_op(1'b0, 1'b0, 2'b10, 1'b0, 32'h0000_5555, 32'h0, 1'b1, 5'd6, 3'b000);
        @(negedge clk);
        idle_in();
        check("post_rst_valid", o_valid, 1'b1);
        check("post_rst_data", o_wb_data, 32'h0000_5555);
        check("post_rst_rd", o_rd_addr, 5'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
